// File: rtl/vta_mem_dpi_pkg.sv
// rtl/vta_mem_dpi_pkg.sv - shared opcodes, FSM states and request type for the VTA memory DPI initiator
package vta_mem_dpi_pkg;

    localparam int DEF_LEN_BITS  = 32;
    localparam int DEF_ADDR_BITS = 64;
    localparam int DEF_DATA_BITS = 64;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // One burst request at the default widths: opcode, byte base address, beats minus one
    typedef struct packed {
        logic                     opcode;
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_LEN_BITS-1:0]  len;
    } req_t;

endpackage

// File: rtl/vta_mem_dpi_beat_cnt.sv
// rtl/vta_mem_dpi_beat_cnt.sv - burst beat counter with clear, increment and last-beat flag
module vta_mem_dpi_beat_cnt
    import vta_mem_dpi_pkg::*;
#(
    parameter int LEN_BITS = DEF_LEN_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    input  logic [LEN_BITS-1:0] len,
    output logic [LEN_BITS-1:0] count,
    output logic                last
);

    // Count accepted beats; a new request restarts the count from zero
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + LEN_BITS'(1);
        end
    end

    // Compare happens before the increment, so len = all-ones fires before any wrap
    assign last = (count == len);

endmodule

// File: rtl/vta_mem_dpi_initiator.sv
// rtl/vta_mem_dpi_initiator.sv - converts accelerator burst requests into VTA memory DPI transactions
module vta_mem_dpi_initiator
    import vta_mem_dpi_pkg::*;
#(
    parameter int LEN_BITS  = DEF_LEN_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_opcode,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]  req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_BITS-1:0] wr_bits,
    input  logic                 wr_last,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_bits,
    output logic                 rd_last,
    output logic                 done,
    output logic                 err,
    output logic                 dpi_req_valid,
    output logic                 dpi_req_opcode,
    output logic [LEN_BITS-1:0]  dpi_req_len,
    output logic [ADDR_BITS-1:0] dpi_req_addr,
    output logic                 dpi_wr_valid,
    output logic [DATA_BITS-1:0] dpi_wr_bits,
    input  logic                 dpi_rd_valid,
    input  logic [DATA_BITS-1:0] dpi_rd_bits,
    output logic                 dpi_rd_ready
);

    state_t              state;
    logic [LEN_BITS-1:0] count;
    logic                cnt_last;
    logic                req_fire;
    logic                wr_fire;
    logic                rd_fire;

    // Handshake lines are forced low while reset is held, even before state has been cleared
    assign req_ready    = !reset && (state == IDLE);
    assign wr_ready     = !reset && (state == WRITE) && !dpi_req_valid;
    assign rd_valid     = !reset && (state == READ) && dpi_rd_valid;
    assign dpi_rd_ready = !reset && (state == READ) && rd_ready;
    assign rd_bits      = dpi_rd_bits;
    assign rd_last      = rd_valid && cnt_last;

    assign req_fire = req_valid && req_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    vta_mem_dpi_beat_cnt #(
        .LEN_BITS (LEN_BITS)
    ) u_beat_cnt (
        .clock (clock),
        .reset (reset),
        .clear (req_fire),
        .inc   (wr_fire || rd_fire),
        .len   (dpi_req_len),
        .count (count),
        .last  (cnt_last)
    );

    // Burst FSM: latch the request, strobe it to the model, then move beats until len+1 are done
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            dpi_req_valid  <= 1'b0;
            dpi_req_opcode <= 1'b0;
            dpi_req_len    <= '0;
            dpi_req_addr   <= '0;
            dpi_wr_valid   <= 1'b0;
            dpi_wr_bits    <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            dpi_req_valid <= 1'b0;
            dpi_wr_valid  <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        dpi_req_valid  <= 1'b1;
                        dpi_req_opcode <= req_opcode;
                        dpi_req_len    <= req_len;
                        dpi_req_addr   <= req_addr;
                        state          <= (req_opcode == OP_WR) ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        dpi_wr_valid <= 1'b1;
                        dpi_wr_bits  <= wr_bits;
                        if (cnt_last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            if (!wr_last) begin
                                err <= 1'b1;
                            end
                        end else if (wr_last) begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_fire && cnt_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vta_mem_dpi_initiator.sv
// tb/tb_vta_mem_dpi_initiator.sv - scoreboard bench for the VTA memory DPI initiator
module tb_vta_mem_dpi_initiator;
    import vta_mem_dpi_pkg::*;

    localparam int LB = 8;
    localparam int AB = 64;
    localparam int DB = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_opcode = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [LB-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DB-1:0] wr_bits = '0;
    logic          wr_last = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DB-1:0] rd_bits;
    logic          rd_last;
    logic          done;
    logic          err;
    logic          dpi_req_valid;
    logic          dpi_req_opcode;
    logic [LB-1:0] dpi_req_len;
    logic [AB-1:0] dpi_req_addr;
    logic          dpi_wr_valid;
    logic [DB-1:0] dpi_wr_bits;
    logic          dpi_rd_valid = 1'b0;
    logic [DB-1:0] dpi_rd_bits = '0;
    logic          dpi_rd_ready;

    vta_mem_dpi_initiator #(
        .LEN_BITS  (LB),
        .ADDR_BITS (AB),
        .DATA_BITS (DB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_bits        (wr_bits),
        .wr_last        (wr_last),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_bits        (rd_bits),
        .rd_last        (rd_last),
        .done           (done),
        .err            (err),
        .dpi_req_valid  (dpi_req_valid),
        .dpi_req_opcode (dpi_req_opcode),
        .dpi_req_len    (dpi_req_len),
        .dpi_req_addr   (dpi_req_addr),
        .dpi_wr_valid   (dpi_wr_valid),
        .dpi_wr_bits    (dpi_wr_bits),
        .dpi_rd_valid   (dpi_rd_valid),
        .dpi_rd_bits    (dpi_rd_bits),
        .dpi_rd_ready   (dpi_rd_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    req_t        exp_req_q[$];
    int          exp_req_cyc_q[$];
    int          strobe_cyc_q[$];
    logic [63:0] exp_wr_q[$];
    int          exp_wr_cyc_q[$];
    logic [63:0] exp_rd_q[$];
    logic        exp_rd_last_q[$];
    int          exp_done_q[$];
    logic        exp_err = 1'b0;
    bit          stray_rd = 1'b0;
    logic [63:0] ref_mem [logic [63:0]];

    req_t        mon_req;
    int          mon_cyc;
    logic [63:0] mon_data;
    logic        mon_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT presented an output with no expectation pending (cycle %0d)", name, cyc);
    endtask

    // Reference memory contents: any unseen address gets a fresh random word
    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (!ref_mem.exists(a)) ref_mem[a] = {$urandom, $urandom};
        return ref_mem[a];
    endfunction

    // Monitor: request strobes, write beats, read transfers and done pulses against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (dpi_req_valid) begin
                if (exp_req_q.size() == 0) begin
                    unexpected("dpi_req_strobe");
                end else begin
                    mon_req = exp_req_q.pop_front();
                    mon_cyc = exp_req_cyc_q.pop_front();
                    chk("dpi_req_opcode", 64'(dpi_req_opcode), 64'(mon_req.opcode));
                    chk("dpi_req_addr", dpi_req_addr, mon_req.addr);
                    chk("dpi_req_len", 64'(dpi_req_len), 64'(mon_req.len));
                    chk("dpi_req_cycle", 64'(cyc), 64'(mon_cyc));
                end
                if (strobe_cyc_q.size() > 0)
                    chk("dpi_req_gap_ge2", 64'(cyc - strobe_cyc_q[$] >= 2), 64'(1));
                strobe_cyc_q.push_back(cyc);
            end
            if (dpi_wr_valid) begin
                if (exp_wr_q.size() == 0) begin
                    unexpected("dpi_wr_beat");
                end else begin
                    mon_data = exp_wr_q.pop_front();
                    mon_cyc  = exp_wr_cyc_q.pop_front();
                    chk("dpi_wr_bits", dpi_wr_bits, mon_data);
                    chk("dpi_wr_cycle", 64'(cyc), 64'(mon_cyc));
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) begin
                    unexpected("rd_beat");
                end else begin
                    mon_data = exp_rd_q.pop_front();
                    mon_last = exp_rd_last_q.pop_front();
                    chk("rd_bits", rd_bits, mon_data);
                    chk("rd_last", 64'(rd_last), 64'(mon_last));
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    unexpected("done_pulse");
                end else begin
                    mon_cyc = exp_done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_cyc));
                end
            end
        end
    end

    // Called at a drive point; returns at the drive point of the request strobe cycle
    task automatic issue_req(input logic op, input logic [63:0] addr, input int len);
        req_t r;
        int   g;
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = addr;
        req_len    = LB'(len);
        for (g = 0; g < 200; g++) begin
            @(negedge clock);
            if (req_ready) break;
            @(posedge clock); #1;
        end
        chk("req_accepted", 64'(g < 200), 64'(1));
        r.opcode = op;
        r.addr   = addr;
        r.len    = 32'(len);
        exp_req_q.push_back(r);
        exp_req_cyc_q.push_back(cyc + 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    // last_pos: beat index carrying wr_last (len = correct, other values = protocol error)
    task automatic do_write(input logic [63:0] addr, input int len, input int last_pos, input int gap_pct);
        int i;
        int g;
        issue_req(OP_WR, addr, len);
        if (last_pos != len) exp_err = 1'b1;
        i = 0;
        for (g = 0; g < 5000 && i <= len; g++) begin
            wr_valid = ($urandom_range(0, 99) >= gap_pct);
            wr_bits  = {$urandom, $urandom};
            wr_last  = (i == last_pos);
            if (stray_rd) begin
                dpi_rd_valid = 1'b1;
                dpi_rd_bits  = {$urandom, $urandom};
                rd_ready     = 1'b1;
            end
            @(negedge clock);
            if (stray_rd) begin
                chk("stray_rd_valid", 64'(rd_valid), 64'(0));
                chk("stray_dpi_rd_ready", 64'(dpi_rd_ready), 64'(0));
            end
            if (wr_valid && wr_ready) begin
                ref_mem[addr + 64'(8 * i)] = wr_bits;
                exp_wr_q.push_back(wr_bits);
                exp_wr_cyc_q.push_back(cyc + 1);
                if (i == len) exp_done_q.push_back(cyc + 1);
                i++;
            end
            @(posedge clock); #1;
        end
        wr_valid     = 1'b0;
        wr_last      = 1'b0;
        dpi_rd_valid = 1'b0;
        rd_ready     = 1'b0;
        chk("wr_beats_issued", 64'(i), 64'(len + 1));
        chk("err_after_write", 64'(err), 64'(exp_err));
    endtask

    // use_pat selects a fixed rd_ready pattern (bit j for cycle j) with the model always valid
    task automatic do_read(input logic [63:0] addr, input int len, input bit use_pat, input logic [3:0] pat,
                           input int valid_pct, input int ready_pct);
        int k;
        int j;
        issue_req(OP_RD, addr, len);
        for (int b = 0; b <= len; b++) begin
            exp_rd_q.push_back(mem_rd(addr + 64'(8 * b)));
            exp_rd_last_q.push_back(b == len);
        end
        k = 0;
        for (j = 0; j < 5000 && k <= len; j++) begin
            dpi_rd_valid = use_pat ? 1'b1 : ($urandom_range(0, 99) < valid_pct);
            dpi_rd_bits  = dpi_rd_valid ? mem_rd(addr + 64'(8 * k)) : {$urandom, $urandom};
            rd_ready     = use_pat ? pat[j % 4] : ($urandom_range(0, 99) < ready_pct);
            @(negedge clock);
            chk("rd_valid_mirror", 64'(rd_valid), 64'(dpi_rd_valid));
            chk("dpi_rd_ready_mirror", 64'(dpi_rd_ready), 64'(rd_ready));
            if (dpi_rd_valid && rd_ready) begin
                if (k == len) exp_done_q.push_back(cyc + 1);
                k++;
            end
            @(posedge clock); #1;
        end
        dpi_rd_valid = 1'b0;
        rd_ready     = 1'b0;
        chk("rd_beats_moved", 64'(k), 64'(len + 1));
        chk("err_after_read", 64'(err), 64'(exp_err));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int len;
        int lp;
        int sel;

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_dpi_rd_ready", 64'(dpi_rd_ready), 64'(0));
        chk("rst_dpi_req_valid", 64'(dpi_req_valid), 64'(0));
        chk("rst_dpi_req_addr", dpi_req_addr, 64'(0));
        chk("rst_dpi_req_len", 64'(dpi_req_len), 64'(0));
        chk("rst_dpi_wr_valid", 64'(dpi_wr_valid), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle_req_ready", 64'(req_ready), 64'(1));
        @(posedge clock); #1;

        // Basic write burst, then a read with the 1,0,1,1 ready pattern
        do_write(64'h1000, 3, 3, 0);
        do_read(64'h2000, 2, 1'b1, 4'b1101, 100, 100);

        // Single-beat write: next request must be accepted in the done cycle
        do_write(64'h3000, 0, 0, 0);
        @(negedge clock);
        chk("len0_done_cycle_done", 64'(done), 64'(1));
        chk("len0_done_cycle_req_ready", 64'(req_ready), 64'(1));
        @(posedge clock); #1;

        // Early wr_last: burst still runs len+1 beats and err sticks across a clean read
        do_write(64'h4000, 2, 1, 0);
        do_read(64'h4800, 1, 1'b0, 4'b0000, 100, 100);
        chk("err_sticky", 64'(err), 64'(1));

        // Reset one beat into a four-beat read
        issue_req(OP_RD, 64'h5000, 3);
        for (int b = 0; b < 4; b++) begin
            exp_rd_q.push_back(mem_rd(64'h5000 + 64'(8 * b)));
            exp_rd_last_q.push_back(b == 3);
        end
        dpi_rd_valid = 1'b1;
        dpi_rd_bits  = mem_rd(64'h5000);
        rd_ready     = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        dpi_rd_bits = mem_rd(64'h5008);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_rd_valid", 64'(rd_valid), 64'(0));
        chk("rstmid_dpi_rd_ready", 64'(dpi_rd_ready), 64'(0));
        chk("rstmid_req_ready", 64'(req_ready), 64'(0));
        chk("rstmid_beats_left", 64'(exp_rd_q.size()), 64'(3));
        @(posedge clock); #1;
        exp_rd_q.delete();
        exp_rd_last_q.delete();
        exp_err = 1'b0;
        @(negedge clock);
        chk("rstmid_dpi_req_addr", dpi_req_addr, 64'(0));
        chk("rstmid_dpi_req_len", 64'(dpi_req_len), 64'(0));
        chk("rstmid_dpi_req_opcode", 64'(dpi_req_opcode), 64'(0));
        chk("rstmid_dpi_wr_bits", dpi_wr_bits, 64'(0));
        chk("rstmid_done", 64'(done), 64'(0));
        chk("rstmid_err", 64'(err), 64'(0));
        @(posedge clock); #1;
        reset        = 1'b0;
        dpi_rd_valid = 1'b0;
        rd_ready     = 1'b0;
        @(posedge clock); #1;
        do_write(64'h6000, 1, 1, 0);

        // Read immediately followed by write with a stray model read beat during WRITE
        do_read(64'h7000, 1, 1'b0, 4'b0000, 100, 100);
        stray_rd = 1'b1;
        do_write(64'h7100, 2, 2, 0);
        stray_rd = 1'b0;

        // Back-to-back continuous writes: strobes exactly len+3 apart
        do_write(64'h8000, 3, 3, 0);
        do_write(64'h8100, 3, 3, 0);
        chk("b2b_write_gap", 64'(strobe_cyc_q[$] - strobe_cyc_q[$-1]), 64'(6));

        // Longest burst: len is all-ones for the counter width
        do_write(64'h10000, (1 << LB) - 1, (1 << LB) - 1, 20);

        // Randomised traffic
        for (int n = 0; n < 30; n++) begin
            op  = $urandom_range(0, 1);
            len = $urandom_range(0, 7);
            if (op == 1) begin
                sel = $urandom_range(0, 9);
                lp  = (sel == 0) ? int'($urandom_range(0, len)) : ((sel == 1) ? len + 1 : len);
                do_write(64'h20000 + 64'(n * 256), len, lp, 30);
            end else begin
                do_read(64'h20000 + 64'($urandom_range(0, 29) * 256), len, 1'b0, 4'b0000, 70, 70);
            end
        end

        repeat (4) @(posedge clock);
        #1;
        chk("q_req_empty", 64'(exp_req_q.size()), 64'(0));
        chk("q_wr_empty", 64'(exp_wr_q.size()), 64'(0));
        chk("q_rd_empty", 64'(exp_rd_q.size()), 64'(0));
        chk("q_done_empty", 64'(exp_done_q.size()), 64'(0));
        chk("final_err", 64'(err), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
